// File: rtl/wb_conmax_pmsel.sv
// Priority/round-robin master selector for the Wishbone crossbar slave port.
// Picks the highest-priority requester, rotating within a level, with optional tenure limit.
module wb_conmax_pmsel #(
    parameter int unsigned NUM_M    = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned PRI_SEL  = 2,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [2*NUM_M-1:0]   conf,
    input  logic [NUM_M-1:0]     req,
    input  logic                 next,
    output logic [SEL_W-1:0]     sel,
    output logic                 gnt_valid,
    output logic [1:0]           gnt_lvl
);
    localparam int unsigned HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int unsigned NUM_LVL = 4;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic [1:0]          gnt_lvl_q, gnt_lvl_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SEL_W-1:0]    ptr_q [NUM_LVL];
    logic [SEL_W-1:0]    ptr_d [NUM_LVL];

    logic [1:0]          lvl_c [NUM_M];
    logic [1:0]          top_lvl_c;
    logic [SEL_W-1:0]    top_ptr_c;
    logic [SEL_W-1:0]    hi_c, lo_c, win_c;
    logic                found_hi_c, found_lo_c;
    logic                any_req_c, cur_req_c, other_req_c, expire_c, arb_c;

    // Effective per-master priority after masking unused conf bits
    always_comb begin
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (PRI_SEL == 0) begin
                lvl_c[i] = 2'd0;
            end else if (PRI_SEL == 1) begin
                lvl_c[i] = {1'b0, conf[2*i]};
            end else begin
                lvl_c[i] = conf[2*i +: 2];
            end
        end
    end

    // Winner: highest level, then first requester above that level's pointer, else wrap to lowest
    always_comb begin
        top_lvl_c = 2'd0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (req[i] && (lvl_c[i] > top_lvl_c)) begin
                top_lvl_c = lvl_c[i];
            end
        end
        top_ptr_c  = ptr_q[top_lvl_c];
        found_hi_c = 1'b0;
        found_lo_c = 1'b0;
        hi_c       = '0;
        lo_c       = '0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (req[i] && (lvl_c[i] == top_lvl_c)) begin
                if (SEL_W'(i) > top_ptr_c) begin
                    if (!found_hi_c) begin
                        found_hi_c = 1'b1;
                        hi_c       = SEL_W'(i);
                    end
                end else if (!found_lo_c) begin
                    found_lo_c = 1'b1;
                    lo_c       = SEL_W'(i);
                end
            end
        end
        win_c = found_hi_c ? hi_c : lo_c;
    end

    // Request status of the current owner versus everyone else
    always_comb begin
        cur_req_c   = 1'b0;
        other_req_c = 1'b0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (sel_q == SEL_W'(i)) begin
                cur_req_c = req[i];
            end else if (req[i]) begin
                other_req_c = 1'b1;
            end
        end
        any_req_c = |req;
        expire_c  = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD)) && other_req_c;
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_valid_d = gnt_valid_q;
        gnt_lvl_d   = gnt_lvl_q;
        hold_d      = hold_q;
        ptr_d       = ptr_q;
        arb_c       = 1'b0;
        case (state_q)
            IDLE:    arb_c = any_req_c;
            GRANT:   arb_c = next || !cur_req_c || expire_c;
            default: arb_c = 1'b0;
        endcase
        if (arb_c) begin
            hold_d = '0;
            if (any_req_c) begin
                state_d            = GRANT;
                sel_d              = win_c;
                gnt_valid_d        = 1'b1;
                gnt_lvl_d          = top_lvl_c;
                ptr_d[top_lvl_c]   = win_c;
            end else begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        end else if ((state_q == GRANT) && (hold_q != HOLD_W'(MAX_HOLD))) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    // Reset points every level at the last master so master 0 is searched first
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_lvl_q   <= 2'd0;
            hold_q      <= '0;
            for (int l = 0; l < int'(NUM_LVL); l++) begin
                ptr_q[l] <= SEL_W'(NUM_M - 1);
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_lvl_q   <= gnt_lvl_d;
            hold_q      <= hold_d;
            ptr_q       <= ptr_d;
        end
    end

    assign sel       = sel_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_lvl   = gnt_lvl_q;

endmodule

// File: tb/tb_wb_conmax_pmsel.sv
// Bench for wb_conmax_pmsel: three configurations share one stimulus stream
// and are checked every cycle against a behavioural arbiter model.
module tb_wb_conmax_pmsel;
    localparam int NI = 3;
    localparam int PRI  [NI] = '{2, 1, 0};
    localparam int HOLD [NI] = '{4, 0, 0};

    logic        clk;
    logic        rst_i;
    logic [15:0] conf;
    logic [7:0]  req;
    logic        next_i;
    logic [2:0]  sel_o   [NI];
    logic        valid_o [NI];
    logic [1:0]  lvl_o   [NI];

    int checks = 0;
    int errors = 0;

    int m_sel   [NI];
    int m_lvl   [NI];
    int m_hold  [NI];
    int m_valid [NI];
    int m_ptr   [NI][4];

    wb_conmax_pmsel #(.NUM_M(8), .SEL_W(3), .PRI_SEL(2), .MAX_HOLD(4)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .conf(conf), .req(req), .next(next_i),
        .sel(sel_o[0]), .gnt_valid(valid_o[0]), .gnt_lvl(lvl_o[0]));
    wb_conmax_pmsel #(.NUM_M(8), .SEL_W(3), .PRI_SEL(1), .MAX_HOLD(0)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .conf(conf), .req(req), .next(next_i),
        .sel(sel_o[1]), .gnt_valid(valid_o[1]), .gnt_lvl(lvl_o[1]));
    wb_conmax_pmsel #(.NUM_M(8), .SEL_W(3), .PRI_SEL(0), .MAX_HOLD(0)) dut_c (
        .clk_i(clk), .rst_i(rst_i), .conf(conf), .req(req), .next(next_i),
        .sel(sel_o[2]), .gnt_valid(valid_o[2]), .gnt_lvl(lvl_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic int eff(input int k, input int i);
        logic [1:0] c;
        c = conf[2*i +: 2];
        if (PRI[k] == 0) return 0;
        if (PRI[k] == 1) return int'(c[0]);
        return int'(c);
    endfunction

    // Arbiter behaviour expressed directly from the rules: priority, then wrap search from pointer+1
    function automatic void model_step(input int k);
        int  top;
        int  idx;
        bit  any;
        bit  cur;
        bit  others;
        bit  ev;
        bit  found;
        if (!rst_i) begin
            m_sel[k] = 0; m_lvl[k] = 0; m_valid[k] = 0; m_hold[k] = 0;
            for (int l = 0; l < 4; l++) m_ptr[k][l] = 7;
            return;
        end
        any    = (req != 8'h00);
        cur    = ((req >> m_sel[k]) & 8'h01) != 8'h00;
        others = 1'b0;
        for (int j = 0; j < 8; j++) if (j != m_sel[k] && req[j]) others = 1'b1;
        if (m_valid[k] == 0) ev = any;
        else ev = next_i || !cur || (HOLD[k] != 0 && m_hold[k] == HOLD[k] && others);
        if (ev) begin
            m_hold[k] = 0;
            if (any) begin
                top = 0;
                for (int i = 0; i < 8; i++) if (req[i] && eff(k, i) > top) top = eff(k, i);
                found = 1'b0;
                for (int s = 1; s <= 8; s++) begin
                    idx = (m_ptr[k][top] + s) % 8;
                    if (!found && req[idx] && eff(k, idx) == top) begin
                        found    = 1'b1;
                        m_sel[k] = idx;
                    end
                end
                m_lvl[k]      = top;
                m_valid[k]    = 1;
                m_ptr[k][top] = m_sel[k];
            end else begin
                m_valid[k] = 0;
            end
        end else if (m_valid[k] != 0 && m_hold[k] < HOLD[k]) begin
            m_hold[k] = m_hold[k] + 1;
        end
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) model_step(k);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("model_valid", k, 32'(valid_o[k]), m_valid[k]);
            if (m_valid[k] != 0 || !rst_i) begin
                chk("model_sel", k, 32'(sel_o[k]), m_sel[k]);
                chk("model_lvl", k, 32'(lvl_o[k]), m_lvl[k]);
            end
        end
    end

    logic [7:0]  req_tab  [16] = '{8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h18, 8'h18, 8'hFF,
                                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h81, 8'h01, 8'h00};
    logic [15:0] conf_tab [16] = '{16'h1B1B, 16'h1B1B, 16'hE4E4, 16'h0000, 16'h0000, 16'h0F0F,
                                   16'h0F0F, 16'h3C96, 16'h3C96, 16'h3C96, 16'h3C96, 16'h3C96,
                                   16'h3C96, 16'h5555, 16'h5555, 16'h0000};
    logic        next_tab [16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_i = 1'b0; conf = '0; req = '0; next_i = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_sel", k, 32'(sel_o[k]), 0);
            chk("rst_valid", k, 32'(valid_o[k]), 0);
            chk("rst_lvl", k, 32'(lvl_o[k]), 0);
        end
        // Equal priorities: rotate between masters 0 and 7
        rst_i = 1'b1; req = 8'h81;
        @(negedge clk);
        chk("rr_first_sel", 0, 32'(sel_o[0]), 0);
        chk("rr_first_valid", 0, 32'(valid_o[0]), 1);
        next_i = 1'b1;
        @(negedge clk);
        chk("rr_second_sel", 0, 32'(sel_o[0]), 7);
        @(negedge clk);
        chk("rr_third_sel", 0, 32'(sel_o[0]), 0);
        // Master 5 alone at level 3
        conf = 16'h5D55; req = 8'hFF; next_i = 1'b1;
        @(negedge clk);
        chk("hipri_sel", 0, 32'(sel_o[0]), 5);
        chk("hipri_lvl", 0, 32'(lvl_o[0]), 3);
        @(negedge clk);
        chk("hipri_keep_sel", 0, 32'(sel_o[0]), 5);
        // Two-level mode ignores the upper conf bit
        conf = 16'hAAAA; req = 8'h30; next_i = 1'b1;
        @(negedge clk);
        chk("mask_sel", 1, 32'(sel_o[1]), 4);
        chk("mask_lvl", 1, 32'(lvl_o[1]), 0);
        // Tenure limit: master 2 then master 3 after four held cycles
        conf = 16'h0000; req = 8'h04; next_i = 1'b1;
        @(negedge clk);
        chk("hold_grant_sel", 0, 32'(sel_o[0]), 2);
        next_i = 1'b0; req = 8'h0C;
        repeat (4) @(negedge clk);
        chk("hold_before_sel", 0, 32'(sel_o[0]), 2);
        @(negedge clk);
        chk("hold_expire_sel", 0, 32'(sel_o[0]), 3);
        chk("hold_nolimit_sel", 1, 32'(sel_o[1]), 2);
        // Owner drops with nobody else requesting
        req = 8'h40; next_i = 1'b1;
        @(negedge clk);
        chk("drop_grant_sel", 0, 32'(sel_o[0]), 6);
        req = 8'h00; next_i = 1'b0;
        @(negedge clk);
        chk("drop_valid", 0, 32'(valid_o[0]), 0);
        chk("drop_sel", 0, 32'(sel_o[0]), 6);
        @(negedge clk);
        req = 8'h02;
        @(negedge clk);
        chk("regrant_sel", 0, 32'(sel_o[0]), 1);
        chk("regrant_valid", 0, 32'(valid_o[0]), 1);
        // Reset in the middle of a grant
        req = 8'h20; next_i = 1'b1;
        @(negedge clk);
        chk("pre_rst_sel", 0, 32'(sel_o[0]), 5);
        rst_i = 1'b0; next_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_sel", 0, 32'(sel_o[0]), 0);
        chk("mid_rst_valid", 0, 32'(valid_o[0]), 0);
        rst_i = 1'b1; req = 8'h60;
        @(negedge clk);
        chk("post_rst_sel", 0, 32'(sel_o[0]), 5);
        // next and owner drop together: a single arbitration
        req = 8'h40; next_i = 1'b1;
        @(negedge clk);
        chk("combo_sel", 0, 32'(sel_o[0]), 6);
        // No event: conf and other requests must not disturb the grant
        conf = 16'hFFFF; req = 8'hC0; next_i = 1'b0;
        @(negedge clk);
        chk("stable_sel", 0, 32'(sel_o[0]), 6);
        chk("stable_lvl", 0, 32'(lvl_o[0]), 0);
        for (int v = 0; v < 16; v++) begin
            req = req_tab[v]; conf = conf_tab[v]; next_i = next_tab[v];
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_conmax_pmsel.md
WB_CONMAX_PMSEL -- requirements
Module: wb_conmax_pmsel

Interface
REQ-001 The block SHALL have parameter NUM_M, default 8, meaning the number of masters arbitrated (2..16).
REQ-002 The block SHALL have parameter SEL_W, default 3, meaning the width of sel and equal to ceil(log2(NUM_M)).
REQ-003 The block SHALL have parameter PRI_SEL, default 2, meaning the priority levels in use: 0 gives 1 level, 1 gives 2 levels, 2 gives 4 levels.
REQ-004 The block SHALL have parameter MAX_HOLD, default 0, meaning the maximum grant tenure in cycles before forced re-arbitration; 0 disables this limit.
REQ-005 clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  reset; one clock; reset is synchronous and active-low.
REQ-007 conf  input  2*NUM_M  per-master priority; master i uses bits [2i+1:2i].
REQ-008 req  input  NUM_M  per-master bus request, level sensitive.
REQ-009 next  input  1  current transfer complete; permits re-arbitration.
REQ-010 sel  output  SEL_W  index of the granted master, registered.
REQ-011 gnt_valid  output  1  sel names an active grant, registered.
REQ-012 gnt_lvl  output  2  priority level of the current grant, registered.

Function
REQ-013 Effective priority of master i SHALL be: 0 when PRI_SEL=0; {1'b0,conf[2i]} when PRI_SEL=1; conf[2i+1:2i] when PRI_SEL=2.
REQ-014 A higher priority value SHALL win over a lower value.
REQ-015 Within the winning level, the winner SHALL be the first requesting master found searching upward with wrap, starting at that level's pointer+1.
REQ-016 The block SHALL hold four level pointers, each SEL_W bits wide; on each grant only the winning level's pointer SHALL be loaded with the winner index.
REQ-017 FSM states SHALL be IDLE and GRANT.
REQ-018 In IDLE, an arbitration event SHALL occur on every cycle in which any req bit is set.
REQ-019 In GRANT, an arbitration event SHALL occur when any of the following holds: next=1; req[sel]=0; hold expiry (REQ-023).
REQ-020 An arbitration event SHALL sample the current req and conf, including req[sel].
- If any req bit is set, the new sel, gnt_lvl and gnt_valid=1 SHALL appear at the following edge, and the state SHALL be GRANT.
- If no req bit is set, gnt_valid SHALL go 0 at the following edge, the state SHALL be IDLE, and sel and gnt_lvl SHALL hold their values.
REQ-021 Latency from req rising in IDLE to gnt_valid=1 SHALL be exactly 1 clock.
REQ-022 While in GRANT with no arbitration event, sel, gnt_lvl and the pointers SHALL be unchanged, regardless of changes on conf or on other req bits.
REQ-023 hold_cnt SHALL have width ceil(log2(MAX_HOLD+1)) and obey the following rules:
- It SHALL clear on every arbitration event.
- It SHALL increment on every GRANT cycle without an arbitration event, saturating at MAX_HOLD.
- Hold expiry SHALL be the condition MAX_HOLD!=0 and hold_cnt==MAX_HOLD and any req[j] set with j!=sel.
REQ-024 When hold expiry re-arbitrates while the current master is still requesting, REQ-015 SHALL apply unchanged; the current master therefore loses to any other requester at the same or a higher level.
REQ-025 When next and the deassertion of req[sel] occur together, the block SHALL perform one arbitration event only.
REQ-026 req bits at index NUM_M or above do not exist; sel SHALL never exceed NUM_M-1.

Reset
REQ-027 While rst_i=0 at a clock edge, the following SHALL be loaded:
- sel=0, gnt_valid=0, gnt_lvl=0;
- state=IDLE, hold_cnt=0;
- all pointers=NUM_M-1, so that master 0 is searched first.
REQ-028 Reset asserted during GRANT SHALL abort the grant at that edge without any arbitration.
REQ-029 The first arbitration event SHALL be possible in the first cycle with rst_i=1.

Verification
REQ-030 Case: reset, then req=8'h81 with all priorities equal at 0 -> next cycle sel=0, gnt_valid=1; pulse next -> sel=7; pulse next -> sel=0.
REQ-031 Case: PRI_SEL=2, conf gives master 5 level 3 and all others level 1, req=8'hFF -> sel=5, gnt_lvl=3; on next with req unchanged, sel stays 5.
REQ-032 Case: PRI_SEL=1, conf[2*i+1]=1 for all i and all other conf bits 0, req=8'h30 -> sel=4, gnt_lvl=0, confirming the high conf bit is masked.
REQ-033 Case: MAX_HOLD=4, master 2 holds req, master 3 requests from cycle 1 -> sel switches to 3 exactly 5 cycles after grant to 2.
REQ-034 Case: granted master 6 drops req with no next and no other requests -> next cycle gnt_valid=0 and sel stays 6; a new req=8'h02 one cycle later -> sel=1 one cycle after that.
REQ-035 Case: rst_i=0 during GRANT with sel=5 -> next cycle sel=0, gnt_valid=0; after release with req=8'h60 -> sel=5.
